// File: rtl/mux_arbiter_if.sv
// Handshake bundle between two requesters, the mux_arbiter and the downstream consumer.
// The arbiter takes the master modport; the requester/consumer side takes slave.
interface mux_arbiter_if #(
   parameter int unsigned WIDTH = 8
);
   logic             req_a;
   logic [WIDTH-1:0] data_a;
   logic             ack_a;
   logic             req_b;
   logic [WIDTH-1:0] data_b;
   logic             ack_b;
   logic             select;
   logic [WIDTH-1:0] out;
   logic             out_valid;
   logic             out_ready;

   modport master (
      input  req_a, data_a, req_b, data_b, out_ready,
      output ack_a, ack_b, select, out, out_valid
   );

   modport slave (
      output req_a, data_a, req_b, data_b, out_ready,
      input  ack_a, ack_b, select, out, out_valid
   );
endinterface

// File: rtl/mux_arbiter.sv
// Two-requester round-robin arbiter feeding one registered valid/ready output stream.
// Optional burst lock enabled by defining MUX_ARBITER_LOCK_EN (adds the lock input).
module mux_arbiter #(
   parameter int unsigned WIDTH = 8
) (
   input logic           clk,
   input logic           reset_n,
`ifdef MUX_ARBITER_LOCK_EN
   input logic           lock,
`endif
   mux_arbiter_if.master bus
);

   typedef enum logic [0:0] {StEmpty, StFull} state_e;

   state_e           state_q, state_d;
   logic             last_grant_q, last_grant_d;
   logic             select_q, select_d;
   logic [WIDTH-1:0] out_q, out_d;

   logic req_a_eff, req_b_eff;
   logic capture, winner;

`ifdef MUX_ARBITER_LOCK_EN
   logic lock_q, granted_q, lock_eff;

   // A lock rising before anything was ever granted has no owner yet, so it is ignored.
   assign lock_eff  = lock & (lock_q | (state_q == StFull) | granted_q);
   assign req_a_eff = bus.req_a & ~(lock_eff & last_grant_q);
   assign req_b_eff = bus.req_b & ~(lock_eff & ~last_grant_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lock_q    <= 1'b0;
         granted_q <= 1'b0;
      end else begin
         lock_q <= lock;
         if (capture) granted_q <= 1'b1;
      end
   end
`else
   assign req_a_eff = bus.req_a;
   assign req_b_eff = bus.req_b;
`endif

   // Ties go to whoever was not served last; a lone request wins outright.
   assign winner  = (req_a_eff & req_b_eff) ? ~last_grant_q : req_b_eff;
   // Gated by reset_n so no ack escapes while reset is asserted.
   assign capture = reset_n & (req_a_eff | req_b_eff) & ((state_q == StEmpty) | bus.out_ready);

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      select_d     = select_q;
      out_d        = out_q;
      unique case (state_q)
         StEmpty: if (capture) state_d = StFull;
         StFull: begin
            if (capture)            state_d = StFull;
            else if (bus.out_ready) state_d = StEmpty;
         end
         default: state_d = StEmpty;
      endcase
      if (capture) begin
         last_grant_d = winner;
         select_d     = winner;
         out_d        = winner ? bus.data_b : bus.data_a;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StEmpty;
         last_grant_q <= 1'b1;
         select_q     <= 1'b0;
         out_q        <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         select_q     <= select_d;
         out_q        <= out_d;
      end
   end

   assign bus.ack_a     = capture & ~winner;
   assign bus.ack_b     = capture & winner;
   assign bus.select    = select_q;
   assign bus.out       = out_q;
   assign bus.out_valid = (state_q == StFull);

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter: directed test-plan scenarios plus randomized traffic
// compared against a behavioural model of the arbitration rules.
module tb_mux_arbiter;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
`ifdef MUX_ARBITER_LOCK_EN
   logic lock = 1'b0;
`endif

   mux_arbiter_if #(.WIDTH(8)) bus ();

   mux_arbiter #(.WIDTH(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
`ifdef MUX_ARBITER_LOCK_EN
      .lock    (lock),
`endif
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit       m_lg;
   bit       m_valid;
   bit [7:0] m_out;
   bit       m_sel;
   bit       m_granted;
   bit       m_lock_q;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_lg = 1'b1; m_valid = 1'b0; m_out = 8'h00; m_sel = 1'b0;
      m_granted = 1'b0; m_lock_q = 1'b0;
   endtask

   task automatic set_in(input bit ra, input bit [7:0] da, input bit rb, input bit [7:0] db,
                         input bit rdy);
      bus.req_a = ra; bus.data_a = da; bus.req_b = rb; bus.data_b = db; bus.out_ready = rdy;
   endtask

   // One clock: inputs already driven after a negedge. Checks acks, then the registered result.
   task automatic cycle();
      bit ra, rb, cap, w, lk;
      #1;
      ra = bus.req_a;
      rb = bus.req_b;
      lk = 1'b0;
`ifdef MUX_ARBITER_LOCK_EN
      lk = lock && !(!m_lock_q && !m_valid && !m_granted);
      if (lk) begin
         if (m_lg) ra = 1'b0;
         else      rb = 1'b0;
      end
      m_lock_q = lock;
`endif
      cap = (ra || rb) && (!m_valid || bus.out_ready);
      w   = (ra && rb) ? !m_lg : rb;
      check("ack_a", bus.ack_a, cap && !w);
      check("ack_b", bus.ack_b, cap && w);
      if (cap) begin
         m_out = w ? bus.data_b : bus.data_a;
         m_sel = w;
         m_lg = w;
         m_valid = 1'b1;
         m_granted = 1'b1;
      end else if (m_valid && bus.out_ready) begin
         m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      check("out_valid", bus.out_valid, m_valid);
      check("out", bus.out, m_out);
      check("select", bus.select, m_sel);
      @(negedge clk);
   endtask

   initial begin
      model_reset();
      // Reset held with a live request: nothing is captured or acked.
      set_in(1'b1, 8'h5A, 1'b0, 8'h00, 1'b1);
      repeat (2) @(negedge clk);
      #1;
      check("rst_out", bus.out, 8'h00);
      check("rst_valid", bus.out_valid, 1'b0);
      check("rst_ack_a", bus.ack_a, 1'b0);
      check("rst_select", bus.select, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      cycle();
      check("first_out", bus.out, 8'h5A);

      // Drain: out_valid falls, out keeps the last word
      set_in(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      cycle();
      check("drain_valid", bus.out_valid, 1'b0);
      check("drain_out", bus.out, 8'h5A);

      // Tie: A was granted last, so B then A alternate from here
      set_in(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
      repeat (4) cycle();

      // Stall with B waiting, then release with no bubble
      set_in(1'b1, 8'h11, 1'b0, 8'h22, 1'b1);
      cycle();
      check("stall_pre", bus.out, 8'h11);
      set_in(1'b0, 8'h11, 1'b1, 8'h22, 1'b0);
      repeat (3) cycle();
      check("stall_hold", bus.out, 8'h11);
      bus.out_ready = 1'b1;
      cycle();
      check("stall_rel", bus.out, 8'h22);

      // Single requester B, then a tie goes to A
      set_in(1'b0, 8'h00, 1'b1, 8'h33, 1'b1);
      cycle();
      bus.data_b = 8'h44;
      cycle();
      check("single_b", bus.out, 8'h44);
      set_in(1'b1, 8'h55, 1'b1, 8'h66, 1'b1);
      cycle();
      check("tie_after_b", bus.select, 1'b0);

`ifdef MUX_ARBITER_LOCK_EN
      // last_grant = A; locked, B alone is not served
      set_in(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      cycle();
      lock = 1'b1;
      set_in(1'b0, 8'h00, 1'b1, 8'h77, 1'b1);
      repeat (2) cycle();
      check("lock_block", bus.out_valid, 1'b0);
      bus.req_a = 1'b1; bus.data_a = 8'h88;
      cycle();
      check("lock_a", bus.out, 8'h88);
      bus.req_a = 1'b0;
      lock = 1'b0;
      cycle();
      check("lock_b", bus.out, 8'h77);
`endif

      // Asynchronous reset mid-operation
      set_in(1'b1, 8'h99, 1'b0, 8'h00, 1'b0);
      cycle();
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      check("mid_rst_out", bus.out, 8'h00);
      check("mid_rst_valid", bus.out_valid, 1'b0);
      check("mid_rst_ack", bus.ack_a, 1'b0);
      check("mid_rst_sel", bus.select, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         set_in(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom),
                1'($urandom_range(0, 3) != 0));
`ifdef MUX_ARBITER_LOCK_EN
         if ($urandom_range(0, 7) == 0) lock = ~lock;
`endif
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mux_arbiter.md
Name: mux_arbiter

Overview:
- Two-requester round-robin arbiter that sits directly upstream of the multiplex component and drives its select line.
- Each requester presents a data word with a req/ack handshake. The block captures the granted word into an output register and presents it downstream with a valid/ready handshake.
- It converts two competing producers into one registered stream for the datapath bus.

Parameters:
- WIDTH, 8, data width of data_a, data_b and out.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_a  input  1  requester A has a valid word on data_a.
- data_a  input  WIDTH  requester A data.
- ack_a  output  1  A's word is captured this cycle (combinational).
- req_b  input  1  requester B has a valid word on data_b.
- data_b  input  WIDTH  requester B data.
- ack_b  output  1  B's word is captured this cycle (combinational).
- select  output  1  source of the word currently held in out: 0 = A, 1 = B (registered).
- out  output  WIDTH  registered output word.
- out_valid  output  1  out holds an untaken word.
- out_ready  input  1  downstream accepts out this cycle.

Behaviour:
- Decided: one clock (clk); reset_n is asynchronous and active-low.
- Reset values, applied immediately on reset_n low and independent of clk:
  - out = 0, out_valid = 0, select = 0, ack_a = ack_b = 0.
  - Internal last_grant = 1, so A wins the first tie.
- States:
  - EMPTY: out_valid = 0.
  - FULL: out_valid = 1.
- capture = (req_a | req_b) & (!out_valid | out_ready).
- Winner on capture:
  - Only req_a high: A wins.
  - Only req_b high: B wins.
  - Both high: the requester != last_grant wins.
- On capture, at the clock edge:
  - out <= winner's data.
  - select <= winner.
  - last_grant <= winner.
  - out_valid <= 1.
  - ack of the winner is high during the capture cycle only; the loser's ack stays 0.
- Transfer: out_valid & out_ready at the edge.
  - With no capture in the same cycle, out_valid <= 0 (FULL -> EMPTY).
  - out and select hold their last values.
- Back-to-back: transfer and capture in the same cycle give FULL -> FULL with the new word. There are no bubbles, so throughput is one word per cycle.
- Latency: req high in EMPTY gives out_valid one cycle later.
- Stall: FULL with out_ready = 0 means no capture.
  - ack_a = ack_b = 0.
  - out, select and out_valid are held stable.
  - Requesters must keep req and data stable until ack.
- A requester dropping req before ack is legal; it is simply not served.
- No req while EMPTY: the state is held and last_grant is unchanged.
- Reset asserted mid-operation: the held word is discarded, all outputs return to reset values, and no ack is issued.

Optional Feature:
- Macro: MUX_ARBITER_LOCK_EN.
- When defined, an extra port exists: lock  input  1.
  - While lock = 1, arbitration is forced to last_grant's requester and round-robin is suspended.
  - If that requester is not requesting, no capture occurs, even if the other requester is.
  - This allows uninterrupted bursts.
  - lock is ignored in the cycle it first rises if out_valid = 0 and last_grant has never been set since reset. In that case normal arbitration applies.
- When undefined, the port is absent and arbitration is always round-robin as above.

Test Plan:
- Reset: hold reset_n = 0 with req_a = 1, data_a = 8'h5A -> out = 0, out_valid = 0, ack_a = 0, select = 0. After release, the first edge captures: out = 8'h5A, select = 0.
- Tie: req_a = req_b = 1, data_a = 8'h11, data_b = 8'h22, out_ready = 1 for 4 cycles -> out sequence 11, 22, 11, 22; select 0, 1, 0, 1; acks alternate each cycle.
- Stall: FULL with out = 8'h11 and out_ready = 0 for 3 cycles while req_b = 1 -> out stays 11, ack_b = 0. Raise out_ready -> ack_b pulses, next out = 8'h22 with no empty cycle.
- Single requester: req_b only, data_b = 8'h33, 8'h44 with out_ready = 1 -> two consecutive words; last_grant = B, so a following tie grants A.
- Drain: one word captured, then no req and out_ready = 1 -> out_valid falls the next cycle; out still reads the last word.
- Lock (with MUX_ARBITER_LOCK_EN): last_grant = A, lock = 1, only req_b = 1 -> no capture. Then req_a = 1 -> A is captured; B is captured after lock = 0.
